dmem_word_arbiter: RTL
======================

Name: dmem_word_arbiter

Overview:
Two-port arbiter and sequencer for the byte-wide data memory. It shares the memory between the processor load/store port (port 0) and a loader/debug port (port 1). Each granted 32-bit word access is serialised into four big-endian byte beats: the byte at addr holds bits 31:24, addr+3 holds bits 7:0. The block sits between the datapath's memread/memwrite/sum/datab signals and the datmem byte array.

Parameters:
ADDR_W, 5, byte-address width; memory depth is 2**ADDR_W bytes (default 32).

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 base byte address
wdata0  in  32  port 0 write word
rdata0  out  32  port 0 read word; registered, held until the next port-0 read completes
ack0  out  1  one-cycle completion pulse for port 0
req1, we1, addr1, wdata1, rdata1, ack1: same as port 0, for port 1
mem_en  out  1  byte access strobe
mem_we  out  1  byte write enable, qualified by mem_en
mem_addr  out  ADDR_W  byte address
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte; valid in the cycle after the mem_en read beat
busy  out  1  high in every non-IDLE state

Behaviour:
- Reset: state IDLE. ack0/ack1/mem_en/mem_we/busy=0. mem_addr/mem_wdata=0. rdata0/rdata1=0. Priority pointer selects port 0.
- Reset mid-transfer: outputs drop immediately and no ack is issued. Bytes already written stay in memory; there is no rollback.
- States: IDLE, XFER (beat counter 0..3), RLAST, DONE.
- IDLE, cycle T: if any req is high, pick the owner. At edge T+1, latch owner, we, addr and wdata, set beat=0, enter XFER.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the port the pointer selects.
  - The pointer moves to the other port at every grant.
- XFER, cycles T+1..T+4:
  - mem_en=1, mem_we=latched we.
  - mem_addr=(base+beat) mod 2**ADDR_W; wraps, no error.
  - mem_wdata=word byte selected by beat; beat 0 is bits 31:24.
- Read capture: mem_rdata is captured into a shift register one cycle after each beat.
- After beat 3: a write goes to DONE; a read goes to RLAST (cycle T+5, captures byte 3), then DONE.
- DONE: ack of the owner is 1 for exactly one cycle. On a read, the owner's rdata updates at DONE entry and is valid while ack is high. The next state is IDLE.
- Latency from req sampled to ack: write 5 cycles (ack at T+5); read 6 cycles (ack at T+6).
- req is ignored outside IDLE. A requester must drop req in the cycle after ack; a req still high in IDLE is a new request.
- Inputs may change after grant; only the latched copies are used.
- At most one mem_en per cycle. mem_we is never high with mem_en low.

Decomposition:
- Shared package/include dmem_arb_pkg: state encoding (IDLE, XFER, RLAST, DONE), BYTES_PER_WORD=4, BEAT_W=2.
- One sub-module, rr_arb2: 2-way round-robin picker. Inputs req[1:0] and pointer; outputs grant index and valid; purely combinational, pointer register in parent.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously; after release, busy=0 and no mem_en until a req.
- Port 0 write, addr=4, wdata=0xDEADBEEF -> beats (4,DE),(5,AD),(6,BE),(7,EF) in cycles T+1..T+4 with mem_we=1; ack0 at T+5; ack1 never.
- Port 1 read, addr=4, memory model holding the bytes above -> four mem_en beats with mem_we=0; ack1 at T+6; rdata1=0xDEADBEEF; rdata0 unchanged.
- Wrap: port 0 write, addr=30, wdata=0x11223344 -> bytes 30:11, 31:22, 0:33, 1:44; a read of addr=30 returns 0x11223344.
- Arbitration: both req from reset -> port 0 first, then port 1, back-to-back. Both raised again -> port 0 first, since the pointer selects port 0 after port 1's grant. Port 1 alone twice -> granted both times.
- Reset mid-write: port 0 writes 0xAABBCCDD to addr=8 over 0x00000000, rst_n pulsed after beat 1 -> mem_en low at once, no ack0. A later read of addr=8 returns 0xAABB0000.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory word arbiter: FSM encoding,
// word geometry and the big-endian byte selector.
package dmem_arb_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BEAT_W         = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RLAST = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Big-endian byte select: beat 0 is bits 31:24, beat 3 is bits 7:0.
  function automatic logic [7:0] byte_of(input logic [31:0] word,
                                         input logic [BEAT_W-1:0] beat);
    return word[{~beat, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the pointer register
// lives in the parent so it only moves when a grant is actually taken.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       valid
);

  // Contention goes to the pointer's port, otherwise to whoever asks.
  always_comb begin
    valid = |req;
    grant = (&req) ? ptr : req[1];
  end

endmodule

// File: rtl/dmem_word_arbiter.sv
// Shares the byte-wide data memory between the load/store port (0) and the
// loader/debug port (1), serialising each 32-bit word into four big-endian
// byte beats and reassembling read bytes into a registered word.
module dmem_word_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic [31:0]       rdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic [31:0]       rdata1,
  output logic              ack1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTES_PER_WORD - 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [23:0]         shift_q;
  logic                ptr_q;
  logic                arb_grant;
  logic                arb_valid;
  logic                take_grant;
  logic                capture;

  rr_arb2 u_arb (
    .req   ({req1, req0}),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign take_grant = (state_q == IDLE) && arb_valid;
  // Read data lags its beat by one cycle, so capture runs from beat 1
  // through RLAST.
  assign capture    = ((state_q == XFER) && (beat_q != '0)) || (state_q == RLAST);

  // State register.
  // NOTE: every clocked assignment is non-blocking so all registers see the
  // pre-edge values of each other, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: four beats, an extra capture cycle for reads, one
  // ack cycle, then back to IDLE.
  // NOTE: the default assignment first keeps this block free of latches on
  // any path that does not reassign state_d.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = XFER;
      XFER:    if (beat_q == LAST_BEAT) state_d = we_q ? DONE : RLAST;
      RLAST:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant latch, beat counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      ptr_q   <= 1'b0;
    end else if (take_grant) begin
      owner_q <= arb_grant;
      we_q    <= arb_grant ? we1    : we0;
      addr_q  <= arb_grant ? addr1  : addr0;
      wdata_q <= arb_grant ? wdata1 : wdata0;
      beat_q  <= '0;
      ptr_q   <= ~arb_grant;
    end else if (state_q == XFER) begin
      beat_q  <= beat_q + BEAT_W'(1);
    end
  end

  // Read assembly: shift in bytes 0..2, then publish the full word to the
  // owner's rdata on the way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      if (capture) shift_q <= {shift_q[15:0], mem_rdata};
      if (state_q == RLAST) begin
        if (owner_q) rdata1 <= {shift_q, mem_rdata};
        else         rdata0 <= {shift_q, mem_rdata};
      end
    end
  end

  // Memory strobes and acks decode straight from registered state, so an
  // asynchronous reset silences them immediately.
  always_comb begin
    mem_en    = (state_q == XFER);
    mem_we    = mem_en && we_q;
    mem_addr  = mem_en ? addr_q + ADDR_W'(beat_q) : '0;
    mem_wdata = mem_en ? byte_of(wdata_q, beat_q) : '0;
    busy      = (state_q != IDLE);
    ack0      = (state_q == DONE) && !owner_q;
    ack1      = (state_q == DONE) &&  owner_q;
  end

endmodule
